// File: rtl/cart_sram_backup_if.sv
// SD block interface between the SRAM backup engine (master) and the HPS block server (slave).
interface cart_sram_backup_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface

// File: rtl/cart_sram_backup.sv
// Cartridge battery-SRAM backup: loads the save image on mount and streams 512-byte blocks
// back to the HPS on request, using the SRAM BRAM's second port.
module cart_sram_backup #(
  parameter int unsigned ADDR_W = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         size_sram,
  input  logic                sram_we,
  input  logic                img_mounted,
  input  logic                img_readonly,
  input  logic [31:0]         img_size,
  input  logic                save_req,
  cart_sram_backup_if.master  sd,
  output logic [ADDR_W-1:0]   bk_addr,
  output logic                bk_we,
  output logic [7:0]          bk_dout,
  input  logic [7:0]          bk_din,
  output logic                busy,
  output logic                dirty
);

  typedef enum logic [2:0] {
    StIdle, StLdReq, StLdXfer, StSvReq, StSvXfer, StNextLd, StNextSv
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         lba_q, lba_d;
  logic [23:0]         ld_last_q, ld_last_d;
  logic                mounted_q, mounted_d;
  logic                readonly_q, readonly_d;
  logic                dirty_q, dirty_d;
  logic                ack_q;
  logic [ADDR_W-1:0]   addr_q;

  logic [16:0]         nblk;
  logic [16:0]         sv_last;
  logic [23:0]         img_blks;
  logic [23:0]         ld_cnt;
  logic                sram_present;
  logic                ack_rise, ack_fall;
  logic [ADDR_W-1:0]   xfer_addr;

  assign nblk         = {size_sram, 1'b0};
  assign sv_last      = nblk - 17'd1;
  assign sram_present = |size_sram;
  // Image may be shorter than the SRAM: load ceil(img_size/512) blocks, never more than nblk.
  assign img_blks     = {1'b0, img_size[31:9]} + 24'(|img_size[8:0]);
  assign ld_cnt       = (img_blks < {7'd0, nblk}) ? img_blks : {7'd0, nblk};

  // HPS ack is a level; edges delimit a block even if a stale ack outlives an abort.
  assign ack_rise  = sd.sd_ack & ~ack_q;
  assign ack_fall  = ~sd.sd_ack & ack_q;
  assign xfer_addr = {lba_q[ADDR_W-10:0], sd.sd_buff_addr};

  always_comb begin
    state_d    = state_q;
    lba_d      = lba_q;
    ld_last_d  = ld_last_q;
    mounted_d  = mounted_q;
    readonly_d = readonly_q;
    dirty_d    = dirty_q;

    case (state_q)
      StIdle: begin
        if (save_req && mounted_q && !readonly_q && dirty_q && sram_present) begin
          lba_d   = 32'd0;
          state_d = StSvReq;
        end
      end
      StLdReq:  if (ack_rise) state_d = StLdXfer;
      StLdXfer: if (ack_fall) state_d = StNextLd;
      StNextLd: begin
        if (lba_q == {8'd0, ld_last_q}) begin
          state_d = StIdle;
          dirty_d = 1'b0;
        end else begin
          lba_d   = lba_q + 32'd1;
          state_d = StLdReq;
        end
      end
      StSvReq:  if (ack_rise) state_d = StSvXfer;
      StSvXfer: if (ack_fall) state_d = StNextSv;
      StNextSv: begin
        if (lba_q == {15'd0, sv_last}) begin
          state_d = StIdle;
          dirty_d = 1'b0;
        end else begin
          lba_d   = lba_q + 32'd1;
          state_d = StSvReq;
        end
      end
      default: state_d = StIdle;
    endcase

    // A mount aborts whatever is in flight and restarts as if from idle.
    if (img_mounted) begin
      mounted_d  = |img_size;
      readonly_d = img_readonly;
      ld_last_d  = ld_cnt - 24'd1;
      if ((|img_size) && sram_present) begin
        lba_d   = 32'd0;
        state_d = StLdReq;
      end else begin
        state_d = StIdle;
      end
    end

    // CPU writes win over the end-of-transfer clear.
    if (sram_we) dirty_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      lba_q      <= 32'd0;
      ld_last_q  <= 24'd0;
      mounted_q  <= 1'b0;
      readonly_q <= 1'b0;
      dirty_q    <= 1'b0;
      ack_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      lba_q      <= lba_d;
      ld_last_q  <= ld_last_d;
      mounted_q  <= mounted_d;
      readonly_q <= readonly_d;
      dirty_q    <= dirty_d;
      ack_q      <= sd.sd_ack;
      if (state_q != StIdle) addr_q <= xfer_addr;
    end
  end

  assign sd.sd_lba      = lba_q;
  assign sd.sd_rd       = (state_q == StLdReq);
  assign sd.sd_wr       = (state_q == StSvReq);
  assign sd.sd_buff_din = bk_din;

  assign bk_addr = (state_q == StIdle) ? addr_q : xfer_addr;
  assign bk_we   = (state_q == StLdXfer) & sd.sd_buff_wr;
  assign bk_dout = sd.sd_buff_dout;
  assign busy    = (state_q != StIdle);
  assign dirty   = dirty_q;

endmodule

// File: tb/tb_cart_sram_backup.sv
// Bench for cart_sram_backup: HPS block-server model, BRAM model, request/data scoreboard.
module tb_cart_sram_backup;
  localparam int unsigned ADDR_W = 18;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       size_sram;
  logic              sram_we_main, race_we, sram_we;
  logic              img_mounted, img_readonly, save_req;
  logic [31:0]       img_size;
  logic [ADDR_W-1:0] bk_addr;
  logic              bk_we;
  logic [7:0]        bk_dout, bk_din;
  logic              busy, dirty;

  cart_sram_backup_if sd_if ();

  cart_sram_backup #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .size_sram   (size_sram),
    .sram_we     (sram_we),
    .img_mounted (img_mounted),
    .img_readonly(img_readonly),
    .img_size    (img_size),
    .save_req    (save_req),
    .sd          (sd_if.master),
    .bk_addr     (bk_addr),
    .bk_we       (bk_we),
    .bk_dout     (bk_dout),
    .bk_din      (bk_din),
    .busy        (busy),
    .dirty       (dirty)
  );

  always #5 clk = ~clk;
  assign sram_we = sram_we_main | race_we;

  // BRAM port B, one-cycle read latency
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_dout;
    bk_din <= mem[bk_addr];
  end

  int          checks = 0;
  int          errors = 0;
  logic [32:0] req_q [$];
  logic [7:0]  data_q [$];
  logic        din_exp_valid = 1'b0;
  logic        chk_data = 1'b0;
  logic        race_arm = 1'b0;
  logic [31:0] race_last = 32'd0;
  int          we_cnt = 0;

  function automatic logic [7:0] pat(input logic [3:0] l, input logic [8:0] n);
    return {l, 4'h0} ^ n[7:0] ^ {n[8], 7'h0} ^ 8'h7A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // HPS block server
  task automatic serve(input logic wr);
    logic [31:0] l;
    l = sd_if.sd_lba;
    sd_if.sd_ack = 1'b1;
    for (int n = 0; n < 512; n++) begin
      @(negedge clk);
      sd_if.sd_buff_addr = 9'(n);
      if (!wr) begin
        sd_if.sd_buff_dout = pat(l[3:0], 9'(n));
        sd_if.sd_buff_wr   = 1'b1;
      end else if (chk_data) begin
        data_q.push_back(pat(l[3:0], 9'(n)));
        din_exp_valid = 1'b1;
      end
    end
    @(negedge clk);
    sd_if.sd_buff_wr   = 1'b0;
    din_exp_valid      = 1'b0;
    sd_if.sd_ack       = 1'b0;
    sd_if.sd_buff_addr = 9'd0;
    if (wr && race_arm && l == race_last) begin
      @(negedge clk);
      race_we = 1'b1;
      @(negedge clk);
      race_we  = 1'b0;
      race_arm = 1'b0;
    end
  endtask

  initial begin
    sd_if.sd_ack       = 1'b0;
    sd_if.sd_buff_addr = 9'd0;
    sd_if.sd_buff_dout = 8'd0;
    sd_if.sd_buff_wr   = 1'b0;
    race_we            = 1'b0;
    forever begin
      @(negedge clk);
      if (sd_if.sd_rd) serve(1'b0);
      else if (sd_if.sd_wr) serve(1'b1);
    end
  end

  // Monitor: pops expected requests / save bytes as the DUT presents them
  initial begin
    logic rd_prev, wr_prev;
    logic [32:0] e;
    rd_prev = 1'b0;
    wr_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bk_we) we_cnt++;
      if (din_exp_valid) begin
        if (data_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL save_byte actual=%0h required=none", sd_if.sd_buff_din);
        end else begin
          check("save_byte", 64'(sd_if.sd_buff_din), 64'(data_q.pop_front()));
        end
      end
      if ((sd_if.sd_rd && !rd_prev) || (sd_if.sd_wr && !wr_prev)) begin
        check("rd_wr_exclusive", 64'(sd_if.sd_rd & sd_if.sd_wr), 64'd0);
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL request actual=wr%0d/lba%0d required=none", sd_if.sd_wr, sd_if.sd_lba);
        end else begin
          e = req_q.pop_front();
          check("request_kind_lba", 64'({sd_if.sd_wr, sd_if.sd_lba}), 64'(e));
        end
      end
      rd_prev = sd_if.sd_rd;
      wr_prev = sd_if.sd_wr;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_mount(input logic [31:0] sz, input logic ro);
    img_size = sz; img_readonly = ro; img_mounted = 1'b1;
    @(negedge clk);
    img_mounted = 1'b0;
  endtask

  task automatic pulse_save();
    save_req = 1'b1;
    @(negedge clk);
    save_req = 1'b0;
  endtask

  task automatic pulse_we();
    sram_we_main = 1'b1;
    @(negedge clk);
    sram_we_main = 1'b0;
  endtask

  task automatic push_reqs(input logic wr, input int first, input int last);
    for (int i = first; i <= last; i++) req_q.push_back({wr, 32'(i)});
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL wait_idle actual=busy required=idle");
    end
  endtask

  task automatic wait_blk(input logic [31:0] l, input int budget);
    int k = 0;
    while (!(sd_if.sd_lba == l && sd_if.sd_ack) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!(sd_if.sd_lba == l && sd_if.sd_ack)) begin
      checks++; errors++;
      $display("FAIL wait_block actual=lba%0d required=lba%0d", sd_if.sd_lba, l);
    end
  endtask

  initial begin
    int we0;
    reset = 1'b1; size_sram = 16'd8; sram_we_main = 1'b0;
    img_mounted = 1'b0; img_readonly = 1'b0; img_size = 32'd0; save_req = 1'b0;
    tick(3);
    check("reset_sd_rd", 64'(sd_if.sd_rd), 64'd0);
    check("reset_sd_wr", 64'(sd_if.sd_wr), 64'd0);
    check("reset_sd_lba", 64'(sd_if.sd_lba), 64'd0);
    check("reset_bk_we", 64'(bk_we), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_dirty", 64'(dirty), 64'd0);
    reset = 1'b0;
    tick(2);

    // Save without a mounted image is ignored
    pulse_we();
    tick(1);
    check("dirty_set_by_we", 64'(dirty), 64'd1);
    pulse_save();
    tick(5);
    check("nomount_busy", 64'(busy), 64'd0);
    check("nomount_sd_wr", 64'(sd_if.sd_wr), 64'd0);

    // 8 KB load
    push_reqs(1'b0, 0, 15);
    pulse_mount(32'd8192, 1'b0);
    wait_idle(20000);
    check("load8k_dirty", 64'(dirty), 64'd0);
    check("load8k_busy", 64'(busy), 64'd0);
    check("load8k_byte_0x610", 64'(mem[18'h610]), 64'h5A);
    tick(4);
    check("idle_bk_addr_hold", 64'(bk_addr), 64'h1E00);

    // Full save with byte-level data check
    pulse_we();
    check("dirty_before_save", 64'(dirty), 64'd1);
    chk_data = 1'b1;
    push_reqs(1'b1, 0, 15);
    pulse_save();
    wait_idle(20000);
    check("save_dirty_clear", 64'(dirty), 64'd0);

    // Clean SRAM: save ignored
    pulse_save();
    tick(5);
    check("clean_busy", 64'(busy), 64'd0);

    // Read-only image: save ignored
    size_sram = 16'd1;
    push_reqs(1'b0, 0, 1);
    pulse_mount(32'd1024, 1'b1);
    wait_idle(5000);
    pulse_we();
    pulse_save();
    tick(5);
    check("readonly_busy", 64'(busy), 64'd0);
    check("readonly_sd_wr", 64'(sd_if.sd_wr), 64'd0);
    check("readonly_dirty", 64'(dirty), 64'd1);

    // CPU write on the final NEXT_SV cycle keeps dirty set
    size_sram = 16'd4;
    push_reqs(1'b0, 0, 7);
    pulse_mount(32'd4096, 1'b0);
    wait_idle(10000);
    check("race_load_dirty", 64'(dirty), 64'd0);
    pulse_we();
    race_last = 32'd7;
    race_arm  = 1'b1;
    push_reqs(1'b1, 0, 7);
    pulse_save();
    wait_idle(10000);
    check("race_dirty_kept", 64'(dirty), 64'd1);

    // Short images and clamping
    size_sram = 16'd32;
    push_reqs(1'b0, 0, 1);
    pulse_mount(32'd1000, 1'b0);
    wait_idle(5000);
    check("short1000_busy", 64'(busy), 64'd0);
    check("short1000_dirty", 64'(dirty), 64'd0);
    push_reqs(1'b0, 0, 1);
    pulse_mount(32'd1024, 1'b0);
    wait_idle(5000);
    check("exact1024_busy", 64'(busy), 64'd0);
    size_sram = 16'd1;
    push_reqs(1'b0, 0, 1);
    pulse_mount(32'd100000, 1'b0);
    wait_idle(5000);
    check("clamp_busy", 64'(busy), 64'd0);
    tick(10);
    check("short_all_requests_seen", 64'(req_q.size()), 64'd0);

    // Mount during save block 5 aborts and reloads from lba 0
    size_sram = 16'd4;
    push_reqs(1'b0, 0, 7);
    pulse_mount(32'd4096, 1'b0);
    wait_idle(10000);
    pulse_we();
    chk_data = 1'b0;
    push_reqs(1'b1, 0, 5);
    pulse_save();
    wait_blk(32'd5, 8000);
    tick(20);
    push_reqs(1'b0, 0, 7);
    pulse_mount(32'd4096, 1'b0);
    check("abort_sd_wr", 64'(sd_if.sd_wr), 64'd0);
    check("abort_sd_rd", 64'(sd_if.sd_rd), 64'd1);
    check("abort_sd_lba", 64'(sd_if.sd_lba), 64'd0);
    wait_idle(20000);
    check("abort_reload_dirty", 64'(dirty), 64'd0);

    // Reset mid-load
    size_sram = 16'd8;
    push_reqs(1'b0, 0, 2);
    pulse_mount(32'd8192, 1'b0);
    wait_blk(32'd2, 4000);
    pulse_we();
    tick(20);
    reset = 1'b1;
    tick(1);
    check("midreset_sd_rd", 64'(sd_if.sd_rd), 64'd0);
    check("midreset_sd_wr", 64'(sd_if.sd_wr), 64'd0);
    check("midreset_sd_lba", 64'(sd_if.sd_lba), 64'd0);
    check("midreset_bk_we", 64'(bk_we), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_dirty", 64'(dirty), 64'd0);
    we0 = we_cnt;
    tick(2);
    reset = 1'b0;
    tick(600);
    check("midreset_no_bk_we", 64'(we_cnt - we0), 64'd0);
    check("midreset_busy_after", 64'(busy), 64'd0);

    check("requests_outstanding", 64'(req_q.size()), 64'd0);
    check("save_bytes_outstanding", 64'(data_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
